// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter: IF/DM arbiter for a single-port RAM; define MEM_ARB_RR_EN for round-robin
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int RAM_LAT = 1
) (
  input  logic              cpu_clk,
  input  logic              cpu_rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic [3:0]        dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              ram_en,
  output logic [3:0]        ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int CNT_W = (RAM_LAT < 2) ? 1 : $clog2(RAM_LAT + 1);
  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(RAM_LAT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_DM = 1'b1;

  logic [CNT_W-1:0] lat_cnt;
  logic             owner;
  logic             eligible;
  logic             if_win;
  logic             dm_win;
  logic             rd_issue;
  logic             ret_now;

  // Port is free when idle or when the outstanding read returns this cycle
  assign eligible = !cpu_rst && ((lat_cnt == '0) || (lat_cnt == CNT_ONE));

`ifdef MEM_ARB_RR_EN
  logic last;

  always_comb begin
    if_win = 1'b0;
    dm_win = 1'b0;
    if (eligible) begin
      if (if_req && dm_req) begin
        if (last == OWN_DM) if_win = 1'b1;
        else                dm_win = 1'b1;
      end else begin
        if_win = if_req;
        dm_win = dm_req;
      end
    end
  end

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst)     last <= OWN_DM;
    else if (dm_win) last <= OWN_DM;
    else if (if_win) last <= OWN_IF;
  end
`else
  assign dm_win = eligible && dm_req;
  assign if_win = eligible && if_req && !dm_req;
`endif

  assign if_gnt   = if_win;
  assign dm_gnt   = dm_win;
  assign rd_issue = if_win || (dm_win && (dm_we == 4'b0000));

  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 4'b0000;
    ram_addr  = '0;
    ram_wdata = '0;
    if (dm_win) begin
      ram_en    = 1'b1;
      ram_we    = dm_we;
      ram_addr  = dm_addr;
      ram_wdata = dm_wdata;
    end else if (if_win) begin
      ram_en    = 1'b1;
      ram_addr  = if_addr;
    end
  end

  assign ret_now   = !cpu_rst && (lat_cnt == CNT_ONE);
  assign if_rvalid = ret_now && (owner == OWN_IF);
  assign dm_rvalid = ret_now && (owner == OWN_DM);
  assign if_rdata  = ram_rdata;
  assign dm_rdata  = ram_rdata;

  // A new read reloads the counter; the returning read's owner is consumed first
  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      lat_cnt <= '0;
      owner   <= OWN_IF;
    end else if (rd_issue) begin
      lat_cnt <= LAT_LOAD;
      owner   <= dm_win ? OWN_DM : OWN_IF;
    end else if (lat_cnt != '0) begin
      lat_cnt <= lat_cnt - CNT_ONE;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter: directed bench, RAM_LAT=1 (u_a) and RAM_LAT=2 (u_b) instances
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mem_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  logic        a_rst, a_if_req, a_if_gnt, a_if_rvalid, a_dm_req, a_dm_gnt, a_dm_rvalid, a_ram_en;
  logic [3:0]  a_dm_we, a_ram_we;
  logic [31:0] a_if_addr, a_if_rdata, a_dm_addr, a_dm_wdata, a_dm_rdata;
  logic [31:0] a_ram_addr, a_ram_wdata, a_ram_rdata;

  logic        b_rst, b_if_req, b_if_gnt, b_if_rvalid, b_dm_req, b_dm_gnt, b_dm_rvalid, b_ram_en;
  logic [3:0]  b_dm_we, b_ram_we;
  logic [31:0] b_if_addr, b_if_rdata, b_dm_addr, b_dm_wdata, b_dm_rdata;
  logic [31:0] b_ram_addr, b_ram_wdata, b_ram_rdata;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RAM_LAT(1)) u_a (
    .cpu_clk(clk), .cpu_rst(a_rst),
    .if_req(a_if_req), .if_addr(a_if_addr), .if_gnt(a_if_gnt),
    .if_rvalid(a_if_rvalid), .if_rdata(a_if_rdata),
    .dm_req(a_dm_req), .dm_we(a_dm_we), .dm_addr(a_dm_addr), .dm_wdata(a_dm_wdata),
    .dm_gnt(a_dm_gnt), .dm_rvalid(a_dm_rvalid), .dm_rdata(a_dm_rdata),
    .ram_en(a_ram_en), .ram_we(a_ram_we), .ram_addr(a_ram_addr),
    .ram_wdata(a_ram_wdata), .ram_rdata(a_ram_rdata)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RAM_LAT(2)) u_b (
    .cpu_clk(clk), .cpu_rst(b_rst),
    .if_req(b_if_req), .if_addr(b_if_addr), .if_gnt(b_if_gnt),
    .if_rvalid(b_if_rvalid), .if_rdata(b_if_rdata),
    .dm_req(b_dm_req), .dm_we(b_dm_we), .dm_addr(b_dm_addr), .dm_wdata(b_dm_wdata),
    .dm_gnt(b_dm_gnt), .dm_rvalid(b_dm_rvalid), .dm_rdata(b_dm_rdata),
    .ram_en(b_ram_en), .ram_we(b_ram_we), .ram_addr(b_ram_addr),
    .ram_wdata(b_ram_wdata), .ram_rdata(b_ram_rdata)
  );

  // RAM models: word index = addr[9:2], preloaded with 0x10000000 + index
  logic [31:0] mem_a [256];
  logic [31:0] mem_b [256];
  logic [31:0] b_p1;

  always @(posedge clk) begin
    if (a_ram_en) begin
      a_ram_rdata <= mem_a[a_ram_addr[9:2]];
      for (int i = 0; i < 4; i++)
        if (a_ram_we[i]) mem_a[a_ram_addr[9:2]][8*i +: 8] = a_ram_wdata[8*i +: 8];
    end
  end

  always @(posedge clk) begin
    b_ram_rdata <= b_p1;
    if (b_ram_en) begin
      b_p1 <= mem_b[b_ram_addr[9:2]];
      for (int i = 0; i < 4; i++)
        if (b_ram_we[i]) mem_b[b_ram_addr[9:2]][8*i +: 8] = b_ram_wdata[8*i +: 8];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        ireq;
    logic [31:0] iaddr;
    logic        dreq;
    logic [3:0]  dwe;
    logic [31:0] daddr;
    logic [31:0] dwd;
    logic        ig, dg, irv, drv, en;
    logic [3:0]  we;
    logic [31:0] addr, wd, rd;
  } vec_t;

  function automatic vec_t mk(input logic ireq, input logic [31:0] iaddr, input logic dreq,
                              input logic [3:0] dwe, input logic [31:0] daddr, input logic [31:0] dwd,
                              input logic ig, input logic dg, input logic irv, input logic drv,
                              input logic en, input logic [3:0] we, input logic [31:0] addr,
                              input logic [31:0] wd, input logic [31:0] rd);
    vec_t v;
    v.ireq = ireq; v.iaddr = iaddr; v.dreq = dreq; v.dwe = dwe; v.daddr = daddr; v.dwd = dwd;
    v.ig = ig; v.dg = dg; v.irv = irv; v.drv = drv; v.en = en; v.we = we;
    v.addr = addr; v.wd = wd; v.rd = rd;
    return v;
  endfunction

  task automatic drive_a(input logic ireq, input logic [31:0] iaddr, input logic dreq,
                         input logic [3:0] dwe, input logic [31:0] daddr, input logic [31:0] dwd);
    a_if_req = ireq; a_if_addr = iaddr; a_dm_req = dreq;
    a_dm_we = dwe; a_dm_addr = daddr; a_dm_wdata = dwd;
  endtask

  task automatic drive_b(input logic ireq, input logic [31:0] iaddr, input logic dreq,
                         input logic [3:0] dwe, input logic [31:0] daddr, input logic [31:0] dwd);
    b_if_req = ireq; b_if_addr = iaddr; b_dm_req = dreq;
    b_dm_we = dwe; b_dm_addr = daddr; b_dm_wdata = dwd;
  endtask

  task automatic chk_b(input string tag, input logic ig, input logic dg, input logic irv,
                       input logic drv, input logic en, input logic [3:0] we,
                       input logic [31:0] addr, input logic [31:0] rd);
    chk({tag, " if_gnt"}, b_if_gnt, ig);
    chk({tag, " dm_gnt"}, b_dm_gnt, dg);
    chk({tag, " if_rvalid"}, b_if_rvalid, irv);
    chk({tag, " dm_rvalid"}, b_dm_rvalid, drv);
    chk({tag, " ram_en"}, b_ram_en, en);
    chk({tag, " ram_we"}, b_ram_we, we);
    chk({tag, " ram_addr"}, b_ram_addr, addr);
    if (irv) chk({tag, " if_rdata"}, b_if_rdata, rd);
  endtask

  localparam logic [31:0] IF0 = 32'h1C00_0000;

  vec_t vecs [19];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem_a[i] = 32'h1000_0000 + i;
      mem_b[i] = 32'h1000_0000 + i;
    end

    //            ireq iaddr      dreq dwe    daddr       dwd           ig dg irv drv en we     addr          wd            rd
    vecs[0]  = mk(0, 0,          0, 4'h0, 0,          0,            0, 0, 0, 0, 0, 4'h0, 0,            0,            0);
    vecs[1]  = mk(1, IF0,        0, 4'h0, 0,          0,            1, 0, 0, 0, 1, 4'h0, IF0,          0,            0);
    vecs[2]  = mk(0, 0,          0, 4'h0, 0,          0,            0, 0, 1, 0, 0, 4'h0, 0,            0,            32'h1000_0000);
    vecs[3]  = mk(1, IF0+4,      1, 4'h0, 32'h100,    0,            0, 1, 0, 0, 1, 4'h0, 32'h100,      0,            0);
    vecs[4]  = mk(1, IF0+4,      0, 4'h0, 0,          0,            1, 0, 0, 1, 1, 4'h0, IF0+4,        0,            32'h1000_0040);
    vecs[5]  = mk(0, 0,          0, 4'h0, 0,          0,            0, 0, 1, 0, 0, 4'h0, 0,            0,            32'h1000_0001);
    vecs[6]  = mk(0, 0,          1, 4'h3, 32'h200,    32'hDEADBEEF, 0, 1, 0, 0, 1, 4'h3, 32'h200,      32'hDEADBEEF, 0);
    vecs[7]  = mk(0, 0,          1, 4'h0, 32'h200,    0,            0, 1, 0, 0, 1, 4'h0, 32'h200,      0,            0);
    vecs[8]  = mk(0, 0,          0, 4'h0, 0,          0,            0, 0, 0, 1, 0, 4'h0, 0,            0,            32'h1000_BEEF);
    vecs[9]  = mk(0, 0,          1, 4'h0, 32'h100,    0,            0, 1, 0, 0, 1, 4'h0, 32'h100,      0,            0);
    vecs[10] = mk(0, 0,          1, 4'hF, 32'h104,    32'h12345678, 0, 1, 0, 1, 1, 4'hF, 32'h104,      32'h12345678, 32'h1000_0040);
    vecs[11] = mk(0, 0,          1, 4'h0, 32'h104,    0,            0, 1, 0, 0, 1, 4'h0, 32'h104,      0,            0);
    vecs[12] = mk(0, 0,          0, 4'h0, 0,          0,            0, 0, 0, 1, 0, 4'h0, 0,            0,            32'h1234_5678);
    vecs[13] = mk(1, IF0+8,      0, 4'h0, 0,          0,            1, 0, 0, 0, 1, 4'h0, IF0+8,        0,            0);
    vecs[14] = mk(1, IF0+12,     0, 4'h0, 0,          0,            1, 0, 1, 0, 1, 4'h0, IF0+12,       0,            32'h1000_0002);
    vecs[15] = mk(0, 0,          0, 4'h0, 0,          0,            0, 0, 1, 0, 0, 4'h0, 0,            0,            32'h1000_0003);
    vecs[16] = mk(0, 0,          1, 4'h0, 32'h0,      0,            0, 1, 0, 0, 1, 4'h0, 32'h0,        0,            0);
    vecs[17] = mk(1, IF0+16,     0, 4'h0, 0,          0,            1, 0, 0, 1, 1, 4'h0, IF0+16,       0,            32'h1000_0000);
    vecs[18] = mk(0, 0,          0, 4'h0, 0,          0,            0, 0, 1, 0, 0, 4'h0, 0,            0,            32'h1000_0004);

    // Reset with requests asserted: everything must stay quiet
    a_rst = 1'b1;
    b_rst = 1'b1;
    drive_a(1, IF0, 1, 4'h0, 32'h100, 0);
    drive_b(1, IF0, 1, 4'hF, 32'h100, 32'h1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst a if_gnt", a_if_gnt, 0);
    chk("rst a dm_gnt", a_dm_gnt, 0);
    chk("rst a ram_en", a_ram_en, 0);
    chk("rst a ram_we", a_ram_we, 0);
    chk("rst a ram_addr", a_ram_addr, 0);
    chk("rst a rvalid", {a_if_rvalid, a_dm_rvalid}, 0);
    chk("rst b ram_wdata", b_ram_wdata, 0);
    chk("rst b dm_gnt", b_dm_gnt, 0);

    @(posedge clk); #1;
    a_rst = 1'b0;
    b_rst = 1'b0;
    drive_b(0, 0, 0, 4'h0, 0, 0);

    for (int r = 0; r < 19; r++) begin
      if (r != 0) begin
        @(posedge clk); #1;
      end
      drive_a(vecs[r].ireq, vecs[r].iaddr, vecs[r].dreq, vecs[r].dwe, vecs[r].daddr, vecs[r].dwd);
      @(negedge clk);
      chk($sformatf("v%0d if_gnt", r), a_if_gnt, vecs[r].ig);
      chk($sformatf("v%0d dm_gnt", r), a_dm_gnt, vecs[r].dg);
      chk($sformatf("v%0d if_rvalid", r), a_if_rvalid, vecs[r].irv);
      chk($sformatf("v%0d dm_rvalid", r), a_dm_rvalid, vecs[r].drv);
      chk($sformatf("v%0d ram_en", r), a_ram_en, vecs[r].en);
      chk($sformatf("v%0d ram_we", r), a_ram_we, vecs[r].we);
      chk($sformatf("v%0d ram_addr", r), a_ram_addr, vecs[r].addr);
      chk($sformatf("v%0d ram_wdata", r), a_ram_wdata, vecs[r].wd);
      if (vecs[r].irv) chk($sformatf("v%0d if_rdata", r), a_if_rdata, vecs[r].rd);
      if (vecs[r].drv) chk($sformatf("v%0d dm_rdata", r), a_dm_rdata, vecs[r].rd);
    end

    // Continuous contention straight out of reset
    @(posedge clk); #1;
    a_rst = 1'b1;
    drive_a(0, 0, 0, 4'h0, 0, 0);
    @(posedge clk); #1;
    a_rst = 1'b0;
    drive_a(1, IF0, 1, 4'h0, 32'h100, 0);
    for (int k = 0; k < 4; k++) begin
      if (k != 0) begin
        @(posedge clk); #1;
      end
      @(negedge clk);
`ifdef MEM_ARB_RR_EN
      chk($sformatf("rr%0d if_gnt", k), a_if_gnt, (k % 2 == 0) ? 1 : 0);
      chk($sformatf("rr%0d dm_gnt", k), a_dm_gnt, (k % 2 == 0) ? 0 : 1);
`else
      chk($sformatf("fix%0d if_gnt", k), a_if_gnt, 0);
      chk($sformatf("fix%0d dm_gnt", k), a_dm_gnt, 1);
`endif
    end
    @(posedge clk); #1;
    drive_a(0, 0, 0, 4'h0, 0, 0);

    // RAM_LAT=2: back-to-back fetches, then a store refused while a read is in flight
    drive_b(1, IF0, 0, 4'h0, 0, 0);
    @(negedge clk);
    chk_b("b0", 1, 0, 0, 0, 1, 4'h0, IF0, 0);
    @(posedge clk); #1;
    drive_b(1, IF0+4, 0, 4'h0, 0, 0);
    @(negedge clk);
    chk_b("b1", 0, 0, 0, 0, 0, 4'h0, 0, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk_b("b2", 1, 0, 1, 0, 1, 4'h0, IF0+4, 32'h1000_0000);
    @(posedge clk); #1;
    drive_b(0, 0, 1, 4'hF, 32'h300, 32'h55AA55AA);
    @(negedge clk);
    chk_b("b3", 0, 0, 0, 0, 0, 4'h0, 0, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk_b("b4", 0, 1, 1, 0, 1, 4'hF, 32'h300, 32'h1000_0001);
    chk("b4 ram_wdata", b_ram_wdata, 32'h55AA55AA);
    @(posedge clk); #1;
    drive_b(0, 0, 0, 4'h0, 0, 0);
    @(negedge clk);
    chk_b("b5", 0, 0, 0, 0, 0, 4'h0, 0, 0);

    // Reset one cycle after a read grant: the read must vanish
    @(posedge clk); #1;
    drive_b(1, IF0+8, 0, 4'h0, 0, 0);
    @(negedge clk);
    chk_b("b6", 1, 0, 0, 0, 1, 4'h0, IF0+8, 0);
    @(posedge clk); #1;
    b_rst = 1'b1;
    @(negedge clk);
    chk_b("b7 rst", 0, 0, 0, 0, 0, 4'h0, 0, 0);
    @(posedge clk); #1;
    b_rst = 1'b0;
    drive_b(1, IF0+12, 0, 4'h0, 0, 0);
    @(negedge clk);
    chk_b("b8", 1, 0, 0, 0, 1, 4'h0, IF0+12, 0);
    @(posedge clk); #1;
    drive_b(0, 0, 0, 4'h0, 0, 0);
    @(negedge clk);
    chk_b("b9", 0, 0, 0, 0, 0, 4'h0, 0, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk_b("b10", 0, 0, 1, 0, 0, 4'h0, 0, 32'h1000_0003);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
